// File: rtl/trace_packet_merger.sv
// Merges NCH trace-packet streams onto one output; per-channel packet-atomic FIFOs
// feed a round-robin arbiter that owns the output for one whole packet at a time.
module trace_packet_merger #(
    parameter  int NCH    = 2,
    parameter  int WORD_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NCH*WORD_W-1:0]   chan_word_i,
    input  logic [NCH-1:0]          chan_valid_i,
    input  logic [NCH-1:0]          chan_last_i,
    output logic [WORD_W-1:0]       packet_word_o,
    output logic                    packet_word_valid_o,
    output logic                    packet_last_o,
    output logic [CH_W-1:0]         packet_chan_o,
    input  logic                    grant_i,
    output logic [NCH*CNT_W-1:0]    drop_cnt_o,
    input  logic                    drop_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [NCH-1:0]    elig;
    logic [NCH-1:0]    pop;
    logic [WORD_W-1:0] head_word [NCH];
    logic [NCH-1:0]    head_last;

    // Per-channel FIFO: wp advances on every stored word, cp only on a packet's last word,
    // so the reader (bounded by cp) never sees a partial packet.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [WORD_W-1:0] mem_word_q [DEPTH];
        logic [DEPTH-1:0]  mem_last_q;
        logic [PW-1:0]     wp_q;
        logic [PW-1:0]     cp_q;
        logic [PW-1:0]     rp_q;
        logic              discard_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [WORD_W-1:0] wr_word;
        logic              wr_valid;
        logic              wr_last;
        logic              full;
        logic              wr_store;
        logic              ovf;

        assign wr_word  = chan_word_i[k*WORD_W +: WORD_W];
        assign wr_valid = chan_valid_i[k];
        assign wr_last  = chan_last_i[k];
        assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        assign wr_store = wr_valid && !discard_q && !full;
        assign ovf      = wr_valid && !discard_q && full;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wp_q      <= '0;
                cp_q      <= '0;
                rp_q      <= '0;
                discard_q <= 1'b0;
            end else begin
                if (pop[k]) begin
                    rp_q <= rp_q + 1'b1;
                end
                if (wr_valid) begin
                    if (discard_q) begin
                        if (wr_last) begin
                            discard_q <= 1'b0;
                        end
                    end else if (full) begin
                        // Roll back to the last committed boundary; cp never passes rp's data.
                        wp_q <= cp_q;
                        if (!wr_last) begin
                            discard_q <= 1'b1;
                        end
                    end else begin
                        wp_q <= wp_q + 1'b1;
                        if (wr_last) begin
                            cp_q <= wp_q + 1'b1;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (wr_store) begin
                mem_word_q[wp_q[AW-1:0]] <= wr_word;
                mem_last_q[wp_q[AW-1:0]] <= wr_last;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (drop_clr_i) begin
                cnt_q <= '0;
            end else if (ovf && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign elig[k]      = (rp_q != cp_q);
        assign head_word[k] = mem_word_q[rp_q[AW-1:0]];
        assign head_last[k] = mem_last_q[rp_q[AW-1:0]];
        assign drop_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
    end

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   owner_q, owner_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   chan_q, chan_d;

    logic [NCH-1:0]    rot;
    logic              sel_found;
    logic [CH_W:0]     sel_off;
    logic [CH_W:0]     sel_sum;
    logic [CH_W-1:0]   sel_ch;
    logic [CH_W:0]     nxt_sum;
    logic [CH_W-1:0]   nxt_owner;
    logic              hs;

    // Rotate eligibility so bit 0 is the RR pointer; lowest set bit is the winner.
    always_comb begin
        rot       = NCH'({elig, elig} >> rr_q);
        sel_found = 1'b0;
        sel_off   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel_found = 1'b1;
                sel_off   = (CH_W+1)'(i);
            end
        end
        sel_sum = {1'b0, rr_q} + sel_off;
        if (sel_sum >= (CH_W+1)'(NCH)) begin
            sel_sum = sel_sum - (CH_W+1)'(NCH);
        end
        sel_ch  = CH_W'(sel_sum);
        nxt_sum = {1'b0, owner_q} + 1'b1;
        if (nxt_sum >= (CH_W+1)'(NCH)) begin
            nxt_sum = nxt_sum - (CH_W+1)'(NCH);
        end
        nxt_owner = CH_W'(nxt_sum);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        word_d  = word_q;
        last_d  = last_q;
        valid_d = valid_q;
        chan_d  = chan_q;
        pop     = '0;
        hs      = valid_q && grant_i;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    owner_d = sel_ch;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (hs && last_q) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    rr_d    = nxt_owner;
                    state_d = S_IDLE;
                end else if ((!valid_q || hs) && !(valid_q && last_q) && elig[owner_q]) begin
                    pop[owner_q] = 1'b1;
                    valid_d      = 1'b1;
                    word_d       = head_word[owner_q];
                    last_d       = head_last[owner_q];
                    chan_d       = owner_q;
                end else if (hs) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            word_q  <= word_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
        end
    end

    assign packet_word_o       = word_q;
    assign packet_word_valid_o = valid_q;
    assign packet_last_o       = last_q;

    if (NCH > 1) begin : g_chan_out
        assign packet_chan_o = chan_q;
    end else begin : g_chan_tie
        assign packet_chan_o = '0;
    end

endmodule

// File: tb/tb_trace_packet_merger.sv
// Directed bench for trace_packet_merger: a per-channel packet model checks every
// handshake and drop counter each cycle; literal expectations pin timing and order.
module tb_trace_packet_merger;

    localparam int NCH    = 2;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 2;
    localparam int CH_W   = 1;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NCH*WORD_W-1:0] chan_word_i;
    logic [NCH-1:0]        chan_valid_i;
    logic [NCH-1:0]        chan_last_i;
    logic [WORD_W-1:0]     packet_word_o;
    logic                  packet_word_valid_o;
    logic                  packet_last_o;
    logic [CH_W-1:0]       packet_chan_o;
    logic                  grant_i;
    logic [NCH*CNT_W-1:0]  drop_cnt_o;
    logic                  drop_clr_i;

    always #5 clk_i = ~clk_i;

    trace_packet_merger #(
        .NCH(NCH), .WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .chan_word_i(chan_word_i), .chan_valid_i(chan_valid_i), .chan_last_i(chan_last_i),
        .packet_word_o(packet_word_o), .packet_word_valid_o(packet_word_valid_o),
        .packet_last_o(packet_last_o), .packet_chan_o(packet_chan_o),
        .grant_i(grant_i), .drop_cnt_o(drop_cnt_o), .drop_clr_i(drop_clr_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] w;
    } ent_t;

    ent_t exp_q  [NCH][$];
    ent_t part_q [NCH][$];
    logic m_disc [NCH];
    int   m_cnt  [NCH];

    int                edge_n = 0;
    int                hs_edge [$];
    logic [WORD_W-1:0] hs_word [$];
    logic              hs_last [$];
    int                hs_chan [$];

    logic              in_pkt = 1'b0;
    int                cur_ch = 0;
    logic              prev_hold = 1'b0;
    logic [WORD_W-1:0] prev_w;
    logic              prev_l;
    logic [CH_W-1:0]   prev_c;

    always @(posedge clk_i) edge_n++;

    // A packet is kept only if every word fits alongside the committed-but-unread words.
    task automatic model_write(input int k, input logic [WORD_W-1:0] w, input logic l);
        if (m_disc[k]) begin
            if (l) m_disc[k] = 1'b0;
        end else if (exp_q[k].size() + part_q[k].size() >= DEPTH) begin
            part_q[k].delete();
            if (!l) m_disc[k] = 1'b1;
            if (m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
        end else begin
            part_q[k].push_back({l, w});
            if (l) begin
                foreach (part_q[k][i]) exp_q[k].push_back(part_q[k][i]);
                part_q[k].delete();
            end
        end
    endtask

    always @(negedge clk_i) begin : compare
        int   c;
        ent_t e;
        if (rst_i) begin
            for (int k = 0; k < NCH; k++) begin
                exp_q[k].delete();
                part_q[k].delete();
                m_disc[k] = 1'b0;
                m_cnt[k]  = 0;
            end
            in_pkt    = 1'b0;
            prev_hold = 1'b0;
            check("rst_valid", packet_word_valid_o, 0);
        end else begin
            for (int k = 0; k < NCH; k++)
                check("drop_cnt", drop_cnt_o[k*CNT_W +: CNT_W], m_cnt[k]);
            if (prev_hold) begin
                check("hold_valid", packet_word_valid_o, 1);
                check("hold_word", packet_word_o, prev_w);
                check("hold_last", packet_last_o, prev_l);
                check("hold_chan", packet_chan_o, prev_c);
            end
            if (packet_word_valid_o && grant_i) begin
                c = int'(packet_chan_o);
                if (in_pkt) check("no_interleave", c, cur_ch);
                if (exp_q[c].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=0x%0h chan=%0d required=none", packet_word_o, c);
                end else begin
                    e = exp_q[c].pop_front();
                    check("out_word", packet_word_o, e.w);
                    check("out_last", packet_last_o, e.last);
                end
                hs_edge.push_back(edge_n + 1);
                hs_word.push_back(packet_word_o);
                hs_last.push_back(packet_last_o);
                hs_chan.push_back(c);
                in_pkt = !packet_last_o;
                cur_ch = c;
            end
            for (int k = 0; k < NCH; k++)
                if (chan_valid_i[k]) model_write(k, chan_word_i[k*WORD_W +: WORD_W], chan_last_i[k]);
            if (drop_clr_i)
                for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
            prev_hold = packet_word_valid_o && !grant_i;
            prev_w    = packet_word_o;
            prev_l    = packet_last_o;
            prev_c    = packet_chan_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] l,
                         input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1, input logic clr);
        chan_valid_i = v;
        chan_last_i  = l;
        chan_word_i  = {w1, w0};
        drop_clr_i   = clr;
        tick();
        chan_valid_i = '0;
        chan_last_i  = '0;
        drop_clr_i   = 1'b0;
    endtask

    task automatic send_pkt(input int ch, input int n, input logic [WORD_W-1:0] base, input logic clr_last);
        logic [NCH-1:0] v;
        v = NCH'(1) << ch;
        for (int i = 0; i < n; i++)
            drive(v, (i == n - 1) ? v : '0, base + WORD_W'(i), base + WORD_W'(i), clr_last && (i == n - 1));
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        while (!packet_word_valid_o && n < limit) begin
            tick();
            n++;
        end
        check(name, packet_word_valid_o, 1);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || packet_word_valid_o) && n < limit) begin
            tick();
            n++;
        end
        check(name, exp_q[0].size() + exp_q[1].size() + int'(packet_word_valid_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int b;
        int ne;
        rst_i        = 1'b1;
        grant_i      = 1'b1;
        chan_valid_i = '0;
        chan_last_i  = '0;
        chan_word_i  = '0;
        drop_clr_i   = 1'b0;
        repeat (3) tick();
        check("reset_valid", packet_word_valid_o, 0);
        check("reset_last", packet_last_o, 0);
        check("reset_chan", packet_chan_o, 0);
        check("reset_word", packet_word_o, 0);
        check("reset_drop", drop_cnt_o, 0);
        rst_i = 1'b0;
        repeat (2) tick();

        // single 3-word packet on ch0, grant held
        b = hs_word.size();
        send_pkt(0, 3, 32'hA000_0001, 1'b0);
        ne = edge_n;
        wait_drain("t1_drain", 30);
        check("t1_count", hs_word.size() - b, 3);
        check("t1_first_edge", hs_edge[b], ne + 3);
        check("t1_edge2", hs_edge[b+1], ne + 4);
        check("t1_edge3", hs_edge[b+2], ne + 5);
        check("t1_w1", hs_word[b], 32'hA000_0001);
        check("t1_w2", hs_word[b+1], 32'hA000_0002);
        check("t1_w3", hs_word[b+2], 32'hA000_0003);
        check("t1_l1", hs_last[b], 0);
        check("t1_l2", hs_last[b+1], 0);
        check("t1_l3", hs_last[b+2], 1);
        check("t1_chan", hs_chan[b] + hs_chan[b+1] + hs_chan[b+2], 0);

        // both channels commit together, RR pointer at 1 -> ch1 first
        b = hs_word.size();
        drive(2'b11, 2'b00, 32'hB000_0001, 32'hC000_0001, 1'b0);
        drive(2'b11, 2'b11, 32'hB000_0002, 32'hC000_0002, 1'b0);
        ne = edge_n;
        wait_drain("t2a_drain", 40);
        check("t2a_count", hs_word.size() - b, 4);
        check("t2a_first_edge", hs_edge[b], ne + 3);
        check("t2a_c0", hs_chan[b], 1);
        check("t2a_c1", hs_chan[b+1], 1);
        check("t2a_c2", hs_chan[b+2], 0);
        check("t2a_c3", hs_chan[b+3], 0);
        check("t2a_w0", hs_word[b], 32'hC000_0001);
        check("t2a_w2", hs_word[b+2], 32'hB000_0001);
        check("t2a_gap", hs_edge[b+2], hs_edge[b+1] + 3);

        // move RR pointer back to 0 with a lone ch1 packet
        send_pkt(1, 1, 32'h6000_0001, 1'b0);
        wait_drain("t2_mid_drain", 30);

        b = hs_word.size();
        drive(2'b11, 2'b00, 32'hB100_0001, 32'hC100_0001, 1'b0);
        drive(2'b11, 2'b11, 32'hB100_0002, 32'hC100_0002, 1'b0);
        wait_drain("t2b_drain", 40);
        check("t2b_count", hs_word.size() - b, 4);
        check("t2b_c0", hs_chan[b], 0);
        check("t2b_c1", hs_chan[b+1], 0);
        check("t2b_c2", hs_chan[b+2], 1);
        check("t2b_c3", hs_chan[b+3], 1);
        check("t2b_w0", hs_word[b], 32'hB100_0001);
        check("t2b_w3", hs_word[b+3], 32'hC100_0002);
        check("t2b_gap", hs_edge[b+2], hs_edge[b+1] + 3);

        // backpressure
        grant_i = 1'b0;
        b = hs_word.size();
        send_pkt(0, 3, 32'hD000_0001, 1'b0);
        wait_valid("t3_valid", 10);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_word", packet_word_o, 32'hD000_0001);
            check("t3_hold_last", packet_last_o, 0);
            check("t3_hold_chan", packet_chan_o, 0);
            tick();
        end
        grant_i = 1'b1;
        wait_drain("t3_drain", 30);
        check("t3_count", hs_word.size() - b, 3);
        check("t3_w1", hs_word[b], 32'hD000_0001);
        check("t3_w2", hs_word[b+1], 32'hD000_0002);
        check("t3_w3", hs_word[b+2], 32'hD000_0003);

        // overflow: 20-word packet into empty FIFO, then a 2-word packet
        grant_i = 1'b0;
        b = hs_word.size();
        send_pkt(0, 20, 32'hE000_0000, 1'b0);
        send_pkt(0, 2, 32'hF000_0001, 1'b0);
        check("t4_drop", drop_cnt_o[CNT_W-1:0], 1);
        grant_i = 1'b1;
        wait_drain("t4_drain", 30);
        check("t4_count", hs_word.size() - b, 2);
        check("t4_w1", hs_word[b], 32'hF000_0001);
        check("t4_w2", hs_word[b+1], 32'hF000_0002);
        check("t4_l2", hs_last[b+1], 1);

        // saturation and clear priority
        drive('0, '0, '0, '0, 1'b1);
        check("t5_clear", drop_cnt_o[CNT_W-1:0], 0);
        for (int i = 0; i < 5; i++) send_pkt(0, 17, 32'h7000_0000, 1'b0);
        check("t5_sat", drop_cnt_o[CNT_W-1:0], 3);
        send_pkt(0, 17, 32'h7100_0000, 1'b1);
        check("t5_clr_prio", drop_cnt_o[CNT_W-1:0], 0);
        check("t5_none_out", hs_word.size() - b, 2);

        // asynchronous reset mid-packet
        send_pkt(1, 17, 32'h8000_0000, 1'b0);
        check("t6_drop1", drop_cnt_o[2*CNT_W-1:CNT_W], 1);
        send_pkt(0, 4, 32'h9000_0001, 1'b0);
        wait_valid("t6_valid", 10);
        tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_rst_valid", packet_word_valid_o, 0);
        check("t6_rst_drop", drop_cnt_o, 0);
        check("t6_rst_last", packet_last_o, 0);
        check("t6_rst_word", packet_word_o, 0);
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        b = hs_word.size();
        send_pkt(1, 2, 32'h5000_0001, 1'b0);
        wait_drain("t6_drain", 30);
        check("t6_count", hs_word.size() - b, 2);
        check("t6_w1", hs_word[b], 32'h5000_0001);
        check("t6_w2", hs_word[b+1], 32'h5000_0002);
        check("t6_chan", hs_chan[b], 1);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
